// File: rtl/ami_ram_ctrl.sv
// ami_ram_ctrl: one-burst-at-a-time sequencer between a single-port RAM and the ami user ports
module ami_ram_ctrl #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 40,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int RAM_AW = 10,
  parameter int RAM_RL = 1,
  parameter int CMD_ID = 0
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  cmd_w,
  input  logic [RAM_AW-1:0]     cmd_a,
  input  logic [AXI_LW-1:0]     cmd_l,
  input  logic                  cmd_e,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [AXI_IW-1:0]     usr_awid,
  output logic [AXI_AW-1:0]     usr_awaddr,
  output logic [AXI_LW-1:0]     usr_awlen,
  output logic [AXI_SW-1:0]     usr_awsize,
  output logic [1:0]            usr_awburst,
  output logic                  usr_awvalid,
  input  logic                  usr_awready,
  output logic [AXI_DW-1:0]     usr_wdata,
  output logic [AXI_DW/8-1:0]   usr_wstrb,
  output logic                  usr_wlast,
  output logic                  usr_wvalid,
  input  logic                  usr_wready,
  input  logic [AXI_IW-1:0]     usr_bid,
  input  logic [1:0]            usr_bresp,
  input  logic                  usr_bvalid,
  output logic                  usr_bready,
  output logic [AXI_IW-1:0]     usr_arid,
  output logic [AXI_AW-1:0]     usr_araddr,
  output logic [AXI_LW-1:0]     usr_arlen,
  output logic [AXI_SW-1:0]     usr_arsize,
  output logic [1:0]            usr_arburst,
  output logic                  usr_arvalid,
  input  logic                  usr_arready,
  input  logic [AXI_IW-1:0]     usr_rid,
  input  logic [AXI_DW-1:0]     usr_rdata,
  input  logic [1:0]            usr_rresp,
  input  logic                  usr_rlast,
  input  logic                  usr_rvalid,
  output logic                  usr_rready,
  output logic                  RAM_CEN,
  output logic [AXI_DW/8-1:0]   RAM_WEN,
  output logic [RAM_AW-1:0]     RAM_A,
  output logic [AXI_DW-1:0]     RAM_D,
  input  logic [AXI_DW-1:0]     RAM_Q
);
  localparam int BW = $clog2(AXI_DW / 8);
  localparam int D  = RAM_RL + 1;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  typedef enum logic [2:0] {IDLE, WR_AW, WR_DATA, WR_RESP, RD_AR, RD_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [RAM_AW-1:0] a_q, a_d;
  logic [AXI_LW-1:0] l_q, l_d, beat_q, beat_d;
  logic [AXI_LW:0]   iss_q, iss_d;
  logic              err_q, err_d;
  logic [RAM_RL-1:0] pipe_q, pipe_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AXI_DW-1:0] fifo_q [D];
  logic              accept, push, pop, ram_rd, ram_wr;
  logic [AXI_AW-1:0] axi_addr;
  logic              unused_ok;
  int                occ;
  assign unused_ok = ^{usr_bid, usr_rid};
  // Prefetch credit counts the current pop so a full pipeline keeps streaming one beat per cycle
  always_comb begin
    accept = state_q == IDLE && cmd_e;
    push   = pipe_q[RAM_RL-1];
    pop    = usr_wvalid && usr_wready;
    occ    = int'(cnt_q) - int'(pop) + $countones(pipe_q);
    ram_rd = (state_q == WR_AW || state_q == WR_DATA) && iss_q <= {1'b0, l_q} && occ < D;
    ram_wr = state_q == RD_DATA && usr_rvalid;
    a_d    = accept ? cmd_a : a_q;
    l_d    = accept ? cmd_l : l_q;
    iss_d  = accept ? '0 : ram_rd ? iss_q + 1'b1 : iss_q;
    pipe_d = RAM_RL'({pipe_q, ram_rd});
    wp_d   = !push ? wp_q : (wp_q == PW'(D - 1)) ? '0 : wp_q + 1'b1;
    rp_d   = !pop ? rp_q : (rp_q == PW'(D - 1)) ? '0 : rp_q + 1'b1;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_e) begin
        err_d   = 1'b0;
        beat_d  = '0;
        state_d = cmd_w ? WR_AW : RD_AR;
      end
      WR_AW:   state_d = usr_awready ? WR_DATA : WR_AW;
      WR_DATA: if (pop) begin
        beat_d  = beat_q + 1'b1;
        state_d = usr_wlast ? WR_RESP : WR_DATA;
      end
      WR_RESP: if (usr_bvalid) begin
        err_d   = err_q | (usr_bresp != 2'b00);
        state_d = DONE;
      end
      RD_AR:   state_d = usr_arready ? RD_DATA : RD_AR;
      RD_DATA: if (usr_rvalid) begin
        err_d   = err_q | (usr_rresp != 2'b00) | (usr_rlast != (beat_q == l_q));
        beat_d  = beat_q + 1'b1;
        state_d = beat_q == l_q ? DONE : RD_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge usr_clk or posedge usr_reset)
    if (usr_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      l_q     <= '0;
      beat_q  <= '0;
      iss_q   <= '0;
      err_q   <= 1'b0;
      pipe_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      l_q     <= l_d;
      beat_q  <= beat_d;
      iss_q   <= iss_d;
      err_q   <= err_d;
      pipe_q  <= pipe_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  always_ff @(posedge usr_clk)
    if (push) fifo_q[wp_q] <= RAM_Q;
  assign axi_addr    = AXI_AW'({a_q, {BW{1'b0}}});
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign err         = err_q;
  assign usr_awid    = AXI_IW'(CMD_ID);
  assign usr_awaddr  = axi_addr;
  assign usr_awlen   = l_q;
  assign usr_awsize  = AXI_SW'(BW);
  assign usr_awburst = 2'b01;
  assign usr_awvalid = state_q == WR_AW;
  assign usr_wvalid  = state_q == WR_DATA && cnt_q != '0;
  assign usr_wdata   = usr_wvalid ? fifo_q[rp_q] : '0;
  assign usr_wstrb   = '1;
  assign usr_wlast   = usr_wvalid && beat_q == l_q;
  assign usr_bready  = state_q == WR_RESP;
  assign usr_arid    = AXI_IW'(CMD_ID);
  assign usr_araddr  = axi_addr;
  assign usr_arlen   = l_q;
  assign usr_arsize  = AXI_SW'(BW);
  assign usr_arburst = 2'b01;
  assign usr_arvalid = state_q == RD_AR;
  assign usr_rready  = state_q == RD_DATA;
  assign RAM_CEN     = !(ram_rd || ram_wr);
  assign RAM_WEN     = ram_wr ? '0 : '1;
  assign RAM_A       = ram_rd ? a_q + RAM_AW'(iss_q) : ram_wr ? a_q + RAM_AW'(beat_q) : '0;
  assign RAM_D       = ram_wr ? usr_rdata : '0;
endmodule

// File: tb/tb_ami_ram_ctrl.sv
// tb_ami_ram_ctrl: randomized scenarios against a burst-level RAM/AXI reference model
module tb_ami_ram_ctrl;
  localparam int DW = 128, AW = 40, IW = 8, LW = 8, SW = 3, RAW = 10, RL = 2;
  logic usr_clk, usr_reset, cmd_w, cmd_e, cmd_ready, busy, done, err;
  logic [RAW-1:0] cmd_a;
  logic [LW-1:0] cmd_l;
  logic [IW-1:0] usr_awid, usr_arid, usr_bid, usr_rid;
  logic [AW-1:0] usr_awaddr, usr_araddr;
  logic [LW-1:0] usr_awlen, usr_arlen;
  logic [SW-1:0] usr_awsize, usr_arsize;
  logic [1:0] usr_awburst, usr_arburst, usr_bresp, usr_rresp;
  logic usr_awvalid, usr_awready, usr_wlast, usr_wvalid, usr_wready, usr_bvalid, usr_bready;
  logic usr_arvalid, usr_arready, usr_rlast, usr_rvalid, usr_rready, RAM_CEN;
  logic [DW-1:0] usr_wdata, usr_rdata, RAM_D, RAM_Q;
  logic [DW/8-1:0] usr_wstrb, RAM_WEN;
  logic [RAW-1:0] RAM_A;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mem [1 << RAW];
  logic [DW-1:0] qpipe [RL];

  ami_ram_ctrl #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW),
                 .RAM_AW(RAW), .RAM_RL(RL), .CMD_ID(0)) dut (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .cmd_w(cmd_w), .cmd_a(cmd_a), .cmd_l(cmd_l),
    .cmd_e(cmd_e), .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
    .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen), .usr_awsize(usr_awsize),
    .usr_awburst(usr_awburst), .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
    .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready), .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
    .usr_bready(usr_bready), .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen),
    .usr_arsize(usr_arsize), .usr_arburst(usr_arburst), .usr_arvalid(usr_arvalid),
    .usr_arready(usr_arready), .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp),
    .usr_rlast(usr_rlast), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .RAM_CEN(RAM_CEN), .RAM_WEN(RAM_WEN), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q));

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  // Sync RAM with RL-cycle read latency; contents re-randomized while reset is held
  always @(posedge usr_clk) begin
    if (usr_reset)
      for (int i = 0; i < (1 << RAW); i++) mem[i] <= {$urandom, $urandom, $urandom, $urandom};
    else if (!RAM_CEN && RAM_WEN == '0)
      mem[RAM_A] <= RAM_D;
    qpipe[0] <= (!RAM_CEN && &RAM_WEN) ? mem[RAM_A] : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < RL; i++) qpipe[i] <= qpipe[i-1];
  end
  assign RAM_Q = qpipe[RL-1];

  task automatic idle_inputs();
    cmd_w = 0; cmd_a = '0; cmd_l = '0; cmd_e = 0;
    usr_awready = 0; usr_wready = 0; usr_bid = '0; usr_bresp = '0; usr_bvalid = 0;
    usr_arready = 0; usr_rid = '0; usr_rdata = '0; usr_rresp = '0; usr_rlast = 0; usr_rvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    usr_reset = 1;
    repeat (3) @(negedge usr_clk);
    #1;
    n_chk++; if ({cmd_ready, busy, done, err} !== 4'b1000) begin n_fail++;
      $display("FAIL reset_status got %b want 1000", {cmd_ready, busy, done, err}); end
    n_chk++; if ({usr_awvalid, usr_wvalid, usr_bready, usr_arvalid, usr_rready} !== 5'b0) begin n_fail++;
      $display("FAIL reset_handshake got %b want 00000", {usr_awvalid, usr_wvalid, usr_bready, usr_arvalid, usr_rready}); end
    n_chk++; if ({RAM_CEN, RAM_WEN} !== {1'b1, {DW/8{1'b1}}}) begin n_fail++;
      $display("FAIL reset_ram_ctl got %b/%h want 1/ffff", RAM_CEN, RAM_WEN); end
    n_chk++; if ({RAM_A, RAM_D} !== '0) begin n_fail++;
      $display("FAIL reset_ram_ad got %h/%h want 0/0", RAM_A, RAM_D); end
    n_chk++; if ({usr_awaddr, usr_araddr, usr_awlen, usr_arlen, usr_wdata, usr_wlast} !== '0) begin n_fail++;
      $display("FAIL reset_fields got aw %h ar %h len %h/%h wdata %h want all 0", usr_awaddr, usr_araddr, usr_awlen, usr_arlen, usr_wdata); end
    @(negedge usr_clk);
    usr_reset = 0;
    @(negedge usr_clk);
  endtask

  task automatic do_write(input string nm, input int a, input int l, input int mode,
                          input int aw_dly, input logic [1:0] br, input bit poke);
    logic [DW-1:0] exp [$];
    int beat = 0, rd_n = 0, dly;
    bit aw_seen = 0, seen_w = 0;
    for (int k = 0; k <= l; k++) exp.push_back(mem[RAW'(a + k)]);
    @(negedge usr_clk);
    cmd_w = 1; cmd_a = RAW'(a); cmd_l = LW'(l); cmd_e = 1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready got %b want 1", nm, cmd_ready); end
    for (int c = 0; c < 400 && beat <= l; c++) begin
      @(negedge usr_clk);
      cmd_e = poke ? 1'($urandom) : 1'b0; cmd_w = 1'($urandom); cmd_a = RAW'($urandom); cmd_l = LW'($urandom);
      usr_awready = c >= aw_dly;
      usr_wready = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom);
      #1;
      n_chk++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL %s busy/ready c%0d got %b want 10", nm, c, {busy, cmd_ready}); end
      if (c == 0) begin
        n_chk++; if ({usr_awvalid, RAM_CEN} !== 2'b10) begin n_fail++; $display("FAIL %s first_cycle awvalid/cen got %b want 10", nm, {usr_awvalid, RAM_CEN}); end
      end
      if (!RAM_CEN) begin
        n_chk++; if (RAM_WEN !== '1 || RAM_A !== RAW'(a + rd_n) || rd_n > l) begin n_fail++;
          $display("FAIL %s ram_read %0d got wen %h a %h want ffff a %h", nm, rd_n, RAM_WEN, RAM_A, RAW'(a + rd_n)); end
        rd_n++;
      end
      if (usr_wvalid && usr_wready) begin
        n_chk++; if (!aw_seen || c < RL || usr_wdata !== exp[beat] || usr_wlast !== (beat == l) || usr_wstrb !== '1) begin n_fail++;
          $display("FAIL %s wbeat %0d c%0d aw_seen %b got %h last %b want %h last %b", nm, beat, c, aw_seen, usr_wdata, usr_wlast, exp[beat], beat == l); end
        beat++;
      end else if (mode == 0 && aw_dly == 0 && seen_w) begin
        n_chk++; n_fail++; $display("FAIL %s bubble c%0d got wvalid %b want 1", nm, c, usr_wvalid);
      end
      n_chk++; if (rd_n - beat > RL + 1) begin n_fail++; $display("FAIL %s fifo_capacity got %0d want <=%0d", nm, rd_n - beat, RL + 1); end
      if (usr_awvalid && usr_awready) begin
        n_chk++; if (usr_awaddr !== AW'(a) * (DW / 8) || usr_awlen !== LW'(l) || usr_awid !== '0 || usr_awsize !== 3'd4 || usr_awburst !== 2'b01) begin n_fail++;
          $display("FAIL %s aw got %h/%h/%h/%h/%h want %h/%h/0/4/1", nm, usr_awaddr, usr_awlen, usr_awid, usr_awsize, usr_awburst, AW'(a) * (DW / 8), LW'(l)); end
        aw_seen = 1;
      end
      if (usr_wvalid) seen_w = 1;
    end
    n_chk++; if (beat <= l || rd_n != l + 1) begin n_fail++; $display("FAIL %s beats got %0d reads %0d want %0d", nm, beat, rd_n, l + 1); end
    dly = $urandom_range(0, 2);
    for (int i = 0; i <= dly; i++) begin
      @(negedge usr_clk);
      cmd_e = 0; usr_wready = 0; usr_bvalid = i == dly; usr_bresp = br;
      #1;
      n_chk++; if ({usr_bready, done} !== 2'b10) begin n_fail++; $display("FAIL %s bready/done got %b want 10", nm, {usr_bready, done}); end
    end
    @(negedge usr_clk);
    usr_bvalid = 0;
    #1;
    n_chk++; if ({done, err} !== {1'b1, br != 2'b00}) begin n_fail++; $display("FAIL %s done/err got %b want %b", nm, {done, err}, {1'b1, br != 2'b00}); end
    @(negedge usr_clk);
    #1;
    n_chk++; if ({done, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL %s after_done got %b want 01", nm, {done, cmd_ready}); end
    idle_inputs();
  endtask

  task automatic do_read(input string nm, input int a, input int l, input int ar_dly, input int rv_mode,
                         input bit fixed, input int resp_beat, input int last_beat, input bit poke);
    logic [DW-1:0] dat [$];
    int k = 0;
    bit ar_seen = 0;
    bit exp_err = (resp_beat >= 0 && resp_beat <= l) || last_beat != l;
    @(negedge usr_clk);
    cmd_w = 0; cmd_a = RAW'(a); cmd_l = LW'(l); cmd_e = 1;
    #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s cmd_ready got %b want 1", nm, cmd_ready); end
    for (int c = 0; c < 400 && k <= l; c++) begin
      @(negedge usr_clk);
      cmd_e = poke ? 1'($urandom) : 1'b0; cmd_w = 1'($urandom); cmd_a = RAW'($urandom); cmd_l = LW'($urandom);
      usr_arready = c >= ar_dly;
      usr_rvalid = ar_seen && (rv_mode == 0 || 1'($urandom));
      usr_rdata = fixed ? DW'(10 + k) : {$urandom, $urandom, $urandom, $urandom};
      usr_rresp = k == resp_beat ? 2'b10 : 2'b00;
      usr_rlast = k == last_beat;
      #1;
      n_chk++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL %s busy/ready c%0d got %b want 10", nm, c, {busy, cmd_ready}); end
      if (c == 0) begin
        n_chk++; if (usr_arvalid !== 1'b1) begin n_fail++; $display("FAIL %s arvalid_first got %b want 1", nm, usr_arvalid); end
      end
      n_chk++; if ({usr_rready, RAM_CEN} !== (ar_seen ? {1'b1, ~usr_rvalid} : 2'b01)) begin n_fail++;
        $display("FAIL %s rready/cen c%0d got %b want %b", nm, c, {usr_rready, RAM_CEN}, ar_seen ? {1'b1, ~usr_rvalid} : 2'b01); end
      if (usr_rvalid && usr_rready) begin
        n_chk++; if (RAM_WEN !== '0 || RAM_A !== RAW'(a + k) || RAM_D !== usr_rdata) begin n_fail++;
          $display("FAIL %s ram_write %0d got wen %h a %h d %h want 0 a %h d %h", nm, k, RAM_WEN, RAM_A, RAM_D, RAW'(a + k), usr_rdata); end
        dat.push_back(usr_rdata);
        k++;
      end
      if (usr_arvalid && usr_arready) begin
        n_chk++; if (usr_araddr !== AW'(a) * (DW / 8) || usr_arlen !== LW'(l) || usr_arid !== '0 || usr_arsize !== 3'd4 || usr_arburst !== 2'b01) begin n_fail++;
          $display("FAIL %s ar got %h/%h/%h/%h/%h want %h/%h/0/4/1", nm, usr_araddr, usr_arlen, usr_arid, usr_arsize, usr_arburst, AW'(a) * (DW / 8), LW'(l)); end
        ar_seen = 1;
      end
    end
    n_chk++; if (k <= l) begin n_fail++; $display("FAIL %s rbeats got %0d want %0d", nm, k, l + 1); end
    @(negedge usr_clk);
    cmd_e = 0; usr_rvalid = 1;
    #1;
    n_chk++; if ({done, err, usr_rready, RAM_CEN} !== {1'b1, exp_err, 2'b01}) begin n_fail++;
      $display("FAIL %s done/err/rready/cen got %b want %b", nm, {done, err, usr_rready, RAM_CEN}, {1'b1, exp_err, 2'b01}); end
    @(negedge usr_clk);
    usr_rvalid = 0;
    #1;
    n_chk++; if ({done, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL %s after_done got %b want 01", nm, {done, cmd_ready}); end
    for (int i = 0; i < dat.size(); i++) begin
      n_chk++; if (mem[RAW'(a + i)] !== dat[i]) begin n_fail++; $display("FAIL %s ram_word %0d got %h want %h", nm, i, mem[RAW'(a + i)], dat[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_write_basic();
    do_write("wr_basic", 'h010, 3, 0, 0, 2'b00, 0);
  endtask

  task automatic test_read_wrap();
    do_read("rd_wrap", 'h3FE, 2, 0, 0, 1, -1, 2, 0);
  endtask

  task automatic test_write_toggle();
    do_write("wr_toggle", $urandom_range(0, 1023), 7, 1, 0, 2'b00, 0);
  endtask

  task automatic test_errors();
    do_read("rd_rresp", $urandom_range(0, 1023), 3, 1, 0, 0, 1, 3, 0);
    do_read("rd_rlast", $urandom_range(0, 1023), 1, 0, 0, 0, -1, 0, 0);
    do_write("wr_bresp", $urandom_range(0, 1023), 2, 0, 2, 2'b10, 0);
  endtask

  task automatic test_busy_ignore();
    do_write("wr_poke", $urandom_range(0, 1023), 5, 2, 1, 2'b00, 1);
    do_read("rd_poke", $urandom_range(0, 1023), 4, 2, 1, 0, -1, 4, 1);
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    @(negedge usr_clk);
    cmd_w = 1; cmd_a = RAW'($urandom); cmd_l = 7; cmd_e = 1;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge usr_clk);
      cmd_e = 0; usr_awready = 1; usr_wready = 0;
      #1;
      hit = usr_wvalid;
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rst_mid reach_wdata got wvalid 0 want 1"); end
    usr_reset = 1;
    #1;
    n_chk++; if ({usr_wvalid, RAM_CEN, usr_awvalid, cmd_ready, busy} !== 5'b01010) begin n_fail++;
      $display("FAIL rst_mid async got %b want 01010", {usr_wvalid, RAM_CEN, usr_awvalid, cmd_ready, busy}); end
    idle_inputs();
    @(negedge usr_clk);
    @(negedge usr_clk);
    usr_reset = 0;
    @(negedge usr_clk);
    #1;
    n_chk++; if ({cmd_ready, busy, done} !== 3'b100) begin n_fail++; $display("FAIL rst_mid release got %b want 100", {cmd_ready, busy, done}); end
    do_write("wr_after_rst", $urandom_range(0, 1023), 4, 0, 0, 2'b00, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      int l = $urandom_range(0, 15);
      if ($urandom % 2 == 1)
        do_write("wr_rand", $urandom_range(0, 1023), l, $urandom_range(0, 2), $urandom_range(0, 3),
                 ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'($urandom));
      else
        do_read("rd_rand", $urandom_range(0, 1023), l, $urandom_range(0, 3), $urandom_range(0, 1), 0,
                ($urandom % 4 == 0) ? $urandom_range(0, l) : -1,
                ($urandom % 4 == 0) ? $urandom_range(0, l) : l, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_write_toggle();
    test_errors();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
